instr_feeder: RTL and testbench

//  Program-side counterpart of the processor datapath. Holds a small program RAM, which is loaded while the block is idle.
//  On start it streams 9-bit instruction and immediate words into the processor's din port, pulsing run once per instruction.

---
 rtl/instr_feeder_if.sv | 44 ++++
 rtl/instr_feeder.sv | 187 ++++++++++++++++++
 tb/tb_instr_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_feeder_if
//  Description : Bundle of the program-load, control and processor handshake
//                signals of instr_feeder.
//                  wr_en/wr_addr/wr_data : program RAM write port
//                  start/prog_len/stop   : program control
//                  done/imm_req          : processor handshake (to feeder)
//                  din/run               : word and issue pulse (to processor)
//                  pc/busy/prog_done/err : status
//                slave  modport : the feeder itself
//                master modport : the environment around the feeder
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_feeder_if #(
    parameter int ADDR_W = 6,
    parameter int WORD_W = 9
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              stop;
    logic              done;
    logic              imm_req;
    logic [WORD_W-1:0] din;
    logic              run;
    logic [ADDR_W:0]   pc;
    logic              busy;
    logic              prog_done;
    logic              err;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, prog_len, stop, done, imm_req,
        output din, run, pc, busy, prog_done, err
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, prog_len, stop, done, imm_req,
        input  din, run, pc, busy, prog_done, err
    );
endinterface
`default_nettype wire

// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_feeder
//  Description : Program-side feeder for the processor datapath. Holds a
//                2**ADDR_W word program RAM (loadable while idle), streams
//                instruction and immediate words onto din, pulses run once
//                per instruction and follows the done/imm_req handshake.
//                Reports normal completion (prog_done), graceful stop and
//                timeout (err).
//  Ports       : clk, rst (synchronous, active high)
//                bus : instr_feeder_if.slave (see interface for signal list)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_feeder #(
    parameter int ADDR_W  = 6,
    parameter int WORD_W  = 9,
    parameter int TIMEOUT = 64
) (
    input  wire logic     clk,
    input  wire logic     rst,
    instr_feeder_if.slave bus
);

    localparam int                 c_tmr_w   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_max = c_tmr_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ISSUE     = 3'd2,
        S_EXEC      = 3'd3,
        S_FETCH_IMM = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [ADDR_W:0]     r_pc,     w_pc_nxt;
    logic [ADDR_W:0]     r_len,    w_len_nxt;
    logic [WORD_W-1:0]   r_din,    w_din_nxt;
    logic                r_run,    w_run_nxt;
    logic                r_busy,   w_busy_nxt;
    logic                r_prog_done, w_prog_done_nxt;
    logic                r_err,    w_err_nxt;
    logic [c_tmr_w-1:0]  r_timer,  w_timer_nxt;
    logic                r_imm_served, w_imm_served_nxt;
    logic                r_imm_phase,  w_imm_phase_nxt;
    logic                r_stop_pend,  w_stop_pend_nxt;
    logic                w_stop;
    logic                w_rd_en;

    logic [WORD_W-1:0]   r_mem [2**ADDR_W];
    logic [WORD_W-1:0]   r_rd_q;

    // A stop seen this very cycle counts as pending already.
    assign w_stop = r_stop_pend | bus.stop;

    // Program RAM: writes only while the feeder reports idle; registered read.
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en && !r_busy) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        if (w_rd_en) begin
            r_rd_q <= r_mem[r_pc[ADDR_W-1:0]];
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_len_nxt        = r_len;
        w_din_nxt        = r_din;
        w_run_nxt        = 1'b0;
        w_prog_done_nxt  = 1'b0;
        w_err_nxt        = r_err;
        w_timer_nxt      = r_timer;
        w_imm_served_nxt = r_imm_served;
        w_imm_phase_nxt  = 1'b0;
        w_stop_pend_nxt  = w_stop;
        w_rd_en          = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_stop_pend_nxt = 1'b0;
                if (bus.start) begin
                    w_pc_nxt    = '0;
                    w_len_nxt   = bus.prog_len;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = (bus.prog_len == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_stop) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_stop) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_din_nxt        = r_rd_q;
                    w_run_nxt        = 1'b1;
                    w_pc_nxt         = r_pc + 1'b1;
                    w_timer_nxt      = '0;
                    w_imm_served_nxt = 1'b0;
                    w_state_nxt      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.done) begin
                    w_state_nxt = ((r_pc >= r_len) || w_stop) ? S_FINISH : S_FETCH;
                end else if (bus.imm_req && !r_imm_served) begin
                    w_imm_served_nxt = 1'b1;
                    w_state_nxt      = S_FETCH_IMM;
                end else if (r_timer == c_tmr_max) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_FETCH_IMM: begin
                // First cycle reads the RAM, second presents the word.
                if (!r_imm_phase) begin
                    w_rd_en         = 1'b1;
                    w_imm_phase_nxt = 1'b1;
                end else begin
                    w_din_nxt   = r_rd_q;
                    w_pc_nxt    = r_pc + 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = S_EXEC;
                end
            end
            S_FINISH: begin
                w_prog_done_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // busy stays up through the prog_done cycle so the two fall together.
        w_busy_nxt = (w_state_nxt != S_IDLE) || (r_state == S_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_len        <= '0;
            r_din        <= '0;
            r_run        <= 1'b0;
            r_busy       <= 1'b0;
            r_prog_done  <= 1'b0;
            r_err        <= 1'b0;
            r_timer      <= '0;
            r_imm_served <= 1'b0;
            r_imm_phase  <= 1'b0;
            r_stop_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_len        <= w_len_nxt;
            r_din        <= w_din_nxt;
            r_run        <= w_run_nxt;
            r_busy       <= w_busy_nxt;
            r_prog_done  <= w_prog_done_nxt;
            r_err        <= w_err_nxt;
            r_timer      <= w_timer_nxt;
            r_imm_served <= w_imm_served_nxt;
            r_imm_phase  <= w_imm_phase_nxt;
            r_stop_pend  <= w_stop_pend_nxt;
        end
    end

    assign bus.din       = r_din;
    assign bus.run       = r_run;
    assign bus.pc        = r_pc;
    assign bus.busy      = r_busy;
    assign bus.prog_done = r_prog_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_feeder
//  Description : Self-checking bench for instr_feeder. A procedural model of
//                the program walk predicts every output each cycle; a simple
//                processor model answers run with done/imm_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_feeder;

    localparam int ADDR_W  = 6;
    localparam int WORD_W  = 9;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1000000;

    logic clk;
    logic rst;
    bit   chk_en = 0;

    instr_feeder_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    instr_feeder #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_run   = 0;
    int n_pd    = 0;
    int n_busy  = 0;
    logic [8:0] run_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] exp_din  = '0;
    logic       exp_run  = 1'b0;
    logic [6:0] exp_pc   = '0;
    logic       exp_busy = 1'b0;
    logic       exp_pd   = 1'b0;
    logic       exp_err  = 1'b0;
    logic [8:0] mem_m [64];
    logic       s_start, s_done, s_imm, s_stop;
    logic [6:0] s_len;
    bit         m_abort;

    // One clock edge: sample inputs, apply reset or a permitted RAM write.
    task automatic step();
        logic old_busy;
        @(posedge clk);
        old_busy = exp_busy;
        s_start  = bus.start;
        s_done   = bus.done;
        s_imm    = bus.imm_req;
        s_stop   = bus.stop;
        s_len    = bus.prog_len;
        exp_run  = 1'b0;
        exp_pd   = 1'b0;
        if (rst) begin
            exp_din = '0; exp_pc = '0; exp_busy = 1'b0; exp_err = 1'b0;
            m_abort = 1;
            return;
        end
        if (bus.wr_en && !old_busy) mem_m[bus.wr_addr] = bus.wr_data;
    endtask

    // Walk one program from the idle edge that may accept start.
    task automatic model_run();
        logic [6:0] len;
        logic [8:0] w;
        logic       pend, served;
        int         t;
        bit         fin;
        step(); if (m_abort) return;
        exp_busy = 1'b0;
        if (!s_start) return;
        exp_pc = '0; exp_err = 1'b0; len = s_len; pend = 1'b0; exp_busy = 1'b1;
        fin = (len == 7'd0);
        while (!fin) begin
            step(); if (m_abort) return;            // fetch
            pend |= s_stop;
            if (pend) break;
            w = mem_m[exp_pc[5:0]];
            step(); if (m_abort) return;            // issue
            pend |= s_stop;
            if (pend) break;
            exp_din = w; exp_run = 1'b1; exp_pc++;
            served = 1'b0; t = 0;
            forever begin
                step(); if (m_abort) return;        // execute
                pend |= s_stop;
                if (s_done) begin
                    fin = (exp_pc >= len) || pend;
                    break;
                end else if (s_imm && !served) begin
                    served = 1'b1;
                    step(); if (m_abort) return;
                    pend |= s_stop;
                    w = mem_m[exp_pc[5:0]];
                    step(); if (m_abort) return;
                    pend |= s_stop;
                    exp_din = w; exp_pc++; t = 0;
                end else if (t == TIMEOUT - 1) begin
                    exp_err = 1'b1; exp_busy = 1'b0;
                    return;
                end else begin
                    t++;
                end
            end
        end
        step(); if (m_abort) return;                // finish
        exp_pd = 1'b1;
    endtask

    initial forever begin
        m_abort = 0;
        model_run();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            check("din",       32'(bus.din),       32'(exp_din));
            check("run",       32'(bus.run),       32'(exp_run));
            check("pc",        32'(bus.pc),        32'(exp_pc));
            check("busy",      32'(bus.busy),      32'(exp_busy));
            check("prog_done", 32'(bus.prog_done), 32'(exp_pd));
            check("err",       32'(bus.err),       32'(exp_err));
            if (bus.run === 1'b1) begin n_run++; run_q.push_back(bus.din); end
            if (bus.prog_done === 1'b1) n_pd++;
            if (bus.busy === 1'b1) n_busy++;
        end
    end

    // ---------------- processor model ----------------
    int p_done_dly = 3;
    bit p_imm      = 0;
    int p_imm_dly  = 1;

    initial begin
        int cnt;
        cnt = 0;
        bus.done    = 1'b0;
        bus.imm_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.run === 1'b1) cnt = 1;
            else if (cnt != 0 && cnt < NEVER) cnt++;
            bus.done    = (cnt != 0) && (cnt == p_done_dly);
            bus.imm_req = p_imm && (cnt != 0) && (cnt >= p_imm_dly) && (cnt < p_done_dly);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(a);
        bus.wr_data = 9'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_prog(input int len);
        bus.prog_len = 7'(len);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic clear_counts();
        n_run = 0; n_pd = 0; n_busy = 0;
        run_q.delete();
    endtask

    task automatic wait_idle(input int max, input bit rnd);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < max) begin
            if (rnd) begin
                bus.wr_en   = ($urandom_range(7) == 0);
                bus.wr_addr = 6'($urandom_range(63));
                bus.wr_data = 9'($urandom_range(511));
                bus.stop    = ($urandom_range(31) == 0);
            end
            @(negedge clk);
            n++;
        end
        bus.wr_en = 1'b0;
        bus.stop  = 1'b0;
        check("wait_idle_bound", 32'(n < max), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_run(input int max);
        int n;
        n = 0;
        while (bus.run !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_run_bound", 32'(n < max), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.start    = 1'b0;
        bus.prog_len = '0;
        bus.stop     = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1;

        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pc",   32'(bus.pc),   32'd0);

        for (int a = 0; a < 64; a++) wr(a, int'($urandom_range(511)));

        // T1 basic
        wr(0, 'h041); wr(1, 'h082); wr(2, 'h0C3);
        p_imm = 0; p_done_dly = 3;
        clear_counts();
        start_prog(3);
        wait_idle(200, 0);
        check("t1_runs", n_run, 3);
        check("t1_din0", 32'(run_q[0]), 32'h041);
        check("t1_din1", 32'(run_q[1]), 32'h082);
        check("t1_din2", 32'(run_q[2]), 32'h0C3);
        check("t1_pc",   32'(bus.pc), 32'd3);
        check("t1_pd",   n_pd, 1);
        check("t1_err",  32'(bus.err), 32'd0);

        // T2 immediate
        wr(0, 'h040); wr(1, 'h1FF);
        p_imm = 1; p_imm_dly = 1; p_done_dly = 4;
        clear_counts();
        start_prog(2);
        wait_idle(200, 0);
        check("t2_runs", n_run, 1);
        check("t2_din",  32'(bus.din), 32'h1FF);
        check("t2_pc",   32'(bus.pc), 32'd2);
        check("t2_pd",   n_pd, 1);

        // T3 empty program
        p_imm = 0; p_done_dly = 3;
        clear_counts();
        start_prog(0);
        wait_idle(50, 0);
        check("t3_runs", n_run, 0);
        check("t3_busy_cycles", n_busy, 2);
        check("t3_pd", n_pd, 1);

        // T4 timeout, then a fresh start clears err
        p_done_dly = NEVER;
        clear_counts();
        start_prog(2);
        wait_idle(300, 0);
        check("t4_err",  32'(bus.err), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_pc",   32'(bus.pc), 32'd1);
        check("t4_pd",   n_pd, 0);
        p_done_dly = 3;
        start_prog(1);
        check("t4_err_clr", 32'(bus.err), 32'd0);
        wait_idle(200, 0);

        // T5 stop during execution, write and start lockout while busy
        clear_counts();
        start_prog(2);
        wait_run(20);
        bus.stop = 1'b1; bus.start = 1'b1; bus.prog_len = 7'd5;
        bus.wr_en = 1'b1; bus.wr_addr = 6'd0; bus.wr_data = 9'h1AA;
        @(negedge clk);
        bus.stop = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
        wait_idle(200, 0);
        check("t5_runs", n_run, 1);
        check("t5_pd",   n_pd, 1);
        clear_counts();
        start_prog(1);
        wait_idle(200, 0);
        check("t5_mem0", 32'(run_q[0]), 32'h040);

        // T6 reset mid-program, then replay from address 0
        wr(2, 'h0C3);
        p_done_dly = NEVER;
        start_prog(3);
        wait_run(20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_din",  32'(bus.din),  32'd0);
        check("t6_run",  32'(bus.run),  32'd0);
        check("t6_pc",   32'(bus.pc),   32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        p_done_dly = 3;
        clear_counts();
        start_prog(3);
        wait_idle(200, 0);
        check("t6_runs", n_run, 3);
        check("t6_din0", 32'(run_q[0]), 32'h040);
        check("t6_din1", 32'(run_q[1]), 32'h1FF);

        // Randomized programs
        for (int it = 0; it < 40; it++) begin
            int len;
            len = ($urandom_range(9) == 0) ? int'($urandom_range(70, 64)) : int'($urandom_range(8));
            p_imm      = ($urandom_range(1) == 1);
            p_imm_dly  = int'($urandom_range(2, 1));
            p_done_dly = p_imm ? p_imm_dly + 3 + int'($urandom_range(2)) : int'($urandom_range(5, 1));
            if ($urandom_range(7) == 0) p_done_dly = NEVER;
            wr(int'($urandom_range(63)), int'($urandom_range(511)));
            start_prog(len);
            wait_idle(3000, ($urandom_range(1) == 1));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
